// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package seqdet_pkg;

   // Default maximum pattern length and the matching fill/len field width.
   localparam int SEQ_MAX_LEN = 8;
   localparam int FILL_W      = $clog2(SEQ_MAX_LEN + 1);

   // Low 'len' bits set; supports lengths up to 32.
   function automatic logic [31:0] len_mask(input int unsigned len);
      logic [31:0] m;
      if (len >= 32)
         m = '1;
      else
         m = (32'd1 << len) - 32'd1;
      return m;
   endfunction

   // A zero or oversize programmed length falls back to the full window.
   function automatic int unsigned clamp_len(input int unsigned len,
                                             input int unsigned max_len);
      int unsigned r;
      if (len == 0 || len > max_len)
         r = max_len;
      else
         r = len;
      return r;
   endfunction

endpackage

// File: rtl/seqdet_sat_cnt.sv
// Saturating up-counter with clear; clear together with increment loads 1.
// Latency: 1 cycle from clr/inc to cnt.
// Backpressure: none; holds at all-ones once saturated.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clr       - clear the count
//   inc       - increment (saturating)
//   cnt       - current count
module seqdet_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         // An event in the clearing cycle still counts.
         cnt <= inc ? W'(1) : '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/seqdet_prog.sv
// Run-time programmable serial sequence detector with mask, length and overlap control.
// Latency: z rises on the edge that samples the final pattern bit (visible one cycle after sampling).
// Backpressure: none; bits are taken whenever en=1, cfg_we takes priority and drops that bit.
//
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   en, x        - bit-valid strobe and serial bit (newest bit enters window bit 0)
//   cfg_we       - loads cfg_pattern/cfg_mask/cfg_len/cfg_overlap, clears window/fill/z
//   clr_cnt      - clears match_cnt
//   z            - one-cycle registered match pulse
//   fill         - valid bits in the window, saturating at the active length
//   match_cnt    - saturating match count
module seqdet_prog
   import seqdet_pkg::*;
#(
   parameter int                MAX_LEN     = SEQ_MAX_LEN,
   parameter int                CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b1001_0000,
   localparam int               LEN_W       = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               x,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [MAX_LEN-1:0] cfg_mask,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               clr_cnt,
   output logic               z,
   output logic [LEN_W-1:0]   fill,
   output logic [CNT_W-1:0]   match_cnt
);

   // Programmed configuration
   logic [MAX_LEN-1:0] pattern;
   logic [MAX_LEN-1:0] mask;
   logic [LEN_W-1:0]   len;
   logic               overlap;

   // Sample window
   logic [MAX_LEN-1:0] win;

   // Next-state view of a shift step
   logic [MAX_LEN-1:0] win_n;
   logic [LEN_W-1:0]   fill_n;
   logic [31:0]        lenmask_full;
   logic [MAX_LEN-1:0] lenmask;
   logic               hit;
   logic [LEN_W-1:0]   cfg_len_c;

   assign cfg_len_c = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));

   always_comb begin
      win_n        = {win[MAX_LEN-2:0], x};
      fill_n       = (fill >= len) ? len : fill + LEN_W'(1);
      lenmask_full = len_mask(32'(len));
      lenmask      = lenmask_full[MAX_LEN-1:0];
      // Bits above len still shift through but are masked out of the compare.
      hit          = en && !cfg_we && (fill_n == len) &&
                     (((win_n ^ pattern) & mask & lenmask) == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pattern <= DEF_PATTERN;
         mask    <= '1;
         len     <= LEN_W'(MAX_LEN);
         overlap <= 1'b1;
         win     <= '0;
         fill    <= '0;
         z       <= 1'b0;
      end else if (cfg_we) begin
         pattern <= cfg_pattern;
         mask    <= cfg_mask;
         len     <= cfg_len_c;
         overlap <= cfg_overlap;
         win     <= '0;
         fill    <= '0;
         z       <= 1'b0;
      end else if (en) begin
         win  <= win_n;
         // Non-overlap restarts the fill so the next match needs len fresh bits.
         fill <= (hit && !overlap) ? '0 : fill_n;
         z    <= hit;
      end else begin
         z <= 1'b0;
      end
   end

   seqdet_sat_cnt #(
      .W (CNT_W)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr_cnt),
      .inc (hit),
      .cnt (match_cnt)
   );

endmodule

// File: tb/tb_seqdet_prog.sv
// Directed self-checking bench for seqdet_prog (default instance plus a 2-bit counter instance).
module tb_seqdet_prog;
   import seqdet_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             x = 1'b0;
   logic             cfg_we = 1'b0;
   logic [7:0]       cfg_pattern = '0;
   logic [7:0]       cfg_mask = '1;
   logic [FILL_W-1:0] cfg_len = '0;
   logic             cfg_overlap = 1'b1;
   logic             clr_cnt = 1'b0;
   logic             z, z2;
   logic [FILL_W-1:0] fill, fill2;
   logic [7:0]       match_cnt;
   logic [1:0]       match_cnt2;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   seqdet_prog #(.MAX_LEN(8), .CNT_W(8), .DEF_PATTERN(8'b1001_0000)) dut (
      .clk(clk), .rst(rst), .en(en), .x(x), .cfg_we(cfg_we),
      .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .clr_cnt(clr_cnt),
      .z(z), .fill(fill), .match_cnt(match_cnt)
   );

   // Same stimulus, never cleared except by rst: exercises counter saturation.
   seqdet_prog #(.MAX_LEN(8), .CNT_W(2), .DEF_PATTERN(8'b1001_0000)) dut2 (
      .clk(clk), .rst(rst), .en(en), .x(x), .cfg_we(cfg_we),
      .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .clr_cnt(1'b0),
      .z(z2), .fill(fill2), .match_cnt(match_cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One clock with the given strobes; outputs are stable 1 time unit after the edge.
   task automatic cyc(input logic e, input logic b, input logic w, input logic c);
      en = e; x = b; cfg_we = w; clr_cnt = c;
      @(posedge clk); #1;
      en = 1'b0; cfg_we = 1'b0; clr_cnt = 1'b0;
   endtask

   task automatic cfg(input logic [7:0] p, input logic [7:0] m,
                      input logic [FILL_W-1:0] l, input logic o, input logic c);
      cfg_pattern = p; cfg_mask = m; cfg_len = l; cfg_overlap = o;
      cyc(1'b0, 1'b0, 1'b1, c);
   endtask

   // Send the low n bits of p MSB-first; zs[k] records z after bit n-1-k... stored per bit index i.
   task automatic send(input logic [7:0] p, input int n, output logic [7:0] zs);
      zs = '0;
      for (int i = n - 1; i >= 0; i--) begin
         cyc(1'b1, p[i], 1'b0, 1'b0);
         zs[n-1-i] = z;
      end
   endtask

   logic [7:0] zs;

   initial begin
      // Reset
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_fill", 32'(fill), 0);
      chk("rst_z", 32'(z), 0);
      chk("rst_cnt", 32'(match_cnt), 0);

      // Default pattern, MSB first
      send(8'b1001_0000, 8, zs);
      chk("def_z_per_bit", 32'(zs), 32'h80);
      chk("def_cnt", 32'(match_cnt), 1);
      chk("def_fill", 32'(fill), 8);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("def_z_drop", 32'(z), 0);

      // Overlap: 10010 over stream 10010010
      cfg(8'b0001_0010, 8'hFF, 5, 1'b1, 1'b1);
      chk("cfg_clr_cnt", 32'(match_cnt), 0);
      send(8'b1001_0010, 8, zs);
      chk("ovl_z_per_bit", 32'(zs), 32'h90);
      chk("ovl_cnt", 32'(match_cnt), 2);

      // Non-overlap, same stream
      cfg(8'b0001_0010, 8'hFF, 5, 1'b0, 1'b1);
      send(8'b1001_0010, 8, zs);
      chk("novl_z_per_bit", 32'(zs), 32'h10);
      chk("novl_fill", 32'(fill), 3);
      chk("novl_cnt", 32'(match_cnt), 1);

      // Mask: 1?1 over len 3
      cfg(8'b0000_0101, 8'b0000_0101, 3, 1'b1, 1'b1);
      send(8'b0000_0111, 3, zs);
      chk("mask_111", 32'(zs), 32'h4);
      cfg(8'b0000_0101, 8'b0000_0101, 3, 1'b1, 1'b0);
      send(8'b0000_0101, 3, zs);
      chk("mask_101", 32'(zs), 32'h4);
      chk("mask_cnt", 32'(match_cnt), 2);
      chk("sat_cnt2", 32'(match_cnt2), 3);

      // Length clamp: len 0 -> 8, mask 0 matches every bit once full
      cfg(8'h00, 8'h00, 0, 1'b1, 1'b1);
      send(8'b0101_0101, 7, zs);
      chk("clamp_fill7", 32'(fill), 7);
      chk("clamp_z7", 32'(z), 0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("clamp_z8", 32'(z), 1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("clamp_fill9", 32'(fill), 8);
      chk("b2b_z9", 32'(z), 1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("b2b_z10", 32'(z), 1);
      chk("b2b_cnt", 32'(match_cnt), 3);

      // en gaps mid-pattern
      cfg(8'b1001_0000, 8'hFF, 8, 1'b1, 1'b1);
      send(8'b0000_1001, 4, zs);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
         chk("gap_z", 32'(z), 0);
         chk("gap_fill", 32'(fill), 4);
      end
      send(8'b0000_0000, 4, zs);
      chk("gap_done_z", 32'(zs), 32'h8);
      chk("gap_cnt", 32'(match_cnt), 1);

      // cfg_we collides with final bit: bit dropped, no match
      cfg(8'b1001_0000, 8'hFF, 8, 1'b1, 1'b0);
      send(8'b0100_1000, 7, zs);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("coll_z", 32'(z), 0);
      chk("coll_fill", 32'(fill), 0);
      chk("coll_cnt_kept", 32'(match_cnt), 1);

      // clr_cnt together with a match
      send(8'b1001_0000, 8, zs);
      chk("pre_clr_cnt", 32'(match_cnt), 2);
      send(8'b0100_1000, 7, zs);
      chk("pre_clr_nomatch", 32'(zs), 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      chk("clr_hit_z", 32'(z), 1);
      chk("clr_hit_cnt", 32'(match_cnt), 1);

      // rst mid-pattern overrides a shift
      send(8'b0000_0100, 3, zs);
      rst = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      chk("mid_rst_fill", 32'(fill), 0);
      chk("mid_rst_z", 32'(z), 0);
      chk("mid_rst_cnt", 32'(match_cnt), 0);
      chk("mid_rst_cnt2", 32'(match_cnt2), 0);
      // Config restored to defaults: default pattern detected again
      send(8'b1001_0000, 8, zs);
      chk("post_rst_def", 32'(zs), 32'h80);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/seqdet_prog.md
Name: seqdet_prog

Overview:
- Parametrised, run-time programmable serial sequence detector.
- Detects a pattern of up to MAX_LEN bits on a 1-bit serial input. Don't-care bits come from a mask. Overlapping or non-overlapping detection is selectable.
- Keeps a saturating match counter and exposes the current fill level for debug.
- Sits after the serial bit source in the lab datapath and replaces fixed-pattern hard-coded FSM detectors.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- CNT_W, 8, width of the match counter.
- DEF_PATTERN, 8'b1001_0000 (MAX_LEN bits wide), pattern loaded at reset.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  bit-valid strobe; x is sampled only when en=1.
- x  in  1  serial data bit; the newest bit enters the window LSB.
- cfg_we  in  1  one-cycle configuration write strobe.
- cfg_pattern  in  MAX_LEN  pattern to match; bit 0 is the most recent bit.
- cfg_mask  in  MAX_LEN  1 = compare this bit, 0 = don't care.
- cfg_len  in  $clog2(MAX_LEN+1)  active pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- clr_cnt  in  1  clears match_cnt.
- z  out  1  registered match pulse, one cycle wide per match.
- fill  out  $clog2(MAX_LEN+1)  valid bits in the window, saturating at len.
- match_cnt  out  CNT_W  saturating count of matches.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port rst.
- Reset values:
  - z=0, fill=0, match_cnt=0, window=0.
  - pattern=DEF_PATTERN, mask=all ones, len=MAX_LEN, overlap=1.
- Config write (cfg_we=1):
  - Registers pattern, mask, len and overlap.
  - Clears window, fill and z.
  - Does not touch match_cnt.
  - If cfg_len is 0 or greater than MAX_LEN, len is stored as MAX_LEN.
- Shift step (cfg_we=0, en=1):
  - win_n = {win[MAX_LEN-2:0], x}.
  - fill_n = min(fill+1, len).
- Match condition: fill_n == len AND ((win_n ^ pattern) & mask & lenmask) == 0, where lenmask = low len bits set.
- On a match:
  - z <= 1 on the same edge. z is therefore high in the cycle after the edge that sampled the final bit (latency 1 from sampling).
  - match_cnt increments, saturating at 2^CNT_W-1.
  - Non-overlap mode: fill <= 0. Overlap mode: fill stays at len.
- No match, or en=0: z <= 0. With en=0, window and fill hold.
- Simultaneous events:
  - cfg_we with en: cfg_we wins, that x is dropped, and no match is possible that cycle.
  - clr_cnt with a match: match_cnt <= 1.
  - clr_cnt alone: match_cnt <= 0.
- rst at any time overrides everything, including a match in progress and a config write.
- Back-to-back matches in overlap mode with a fully masked or periodic pattern give z high on consecutive cycles.
- Window bits above len are ignored by the compare but still shifted.

Decomposition:
- Package seqdet_pkg holds:
  - the function computing lenmask from len;
  - the localparam FILL_W = $clog2(MAX_LEN+1);
  - the clamp function for cfg_len.
- One sub-module, seqdet_sat_cnt: a parametrised saturating counter with clear and increment inputs, where clear+inc gives 1.
- Window, fill logic and compare stay in the top module.

Test Plan:
- Reset, then read back: fill=0, z=0, match_cnt=0. Then shift DEF_PATTERN MSB-first with en=1 → z=1 exactly one cycle after the 8th bit and match_cnt=1.
- Overlap: cfg pattern=5'b10010, len=5, mask=all ones, overlap=1; stream 1,0,0,1,0,0,1,0 → z pulses after bit 5 and after bit 8, match_cnt=2.
- Non-overlap: same config and stream with overlap=0 → one z pulse after bit 5; fill=3 after bit 8; match_cnt=1.
- Mask and length clamp:
  - pattern=3'b101, mask=3'b101, len=3; streams 1,1,1 and 1,0,1 (cfg rewritten between streams) → each gives a match.
  - Separately, cfg_len=0 → fill saturates at 8 (len stored as MAX_LEN).
- Gaps and collisions:
  - en low for 3 cycles mid-pattern → no z; the pattern completes correctly after en returns.
  - cfg_we in the same cycle as the final pattern bit → no z, fill=0.
- Counter behaviour:
  - CNT_W=2 with 5 matches → match_cnt saturates at 3.
  - clr_cnt coinciding with a match → match_cnt=1.
  - rst asserted mid-pattern → all outputs at reset values on the next cycle.
